elevator_request_ctrl: RTL

Parametrised request register and travel-direction controller for an N-floor elevator. Latches hall-up, hall-down and car (in-cabin) button presses per floor. Clears each request when the car opens its door at that floor in a matching direction. Produces registered travel direction plus combinational above/below/here/stop summaries for the motion and door controllers.

---
 rtl/elevator_request_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/elevator_request_ctrl.sv
// elevator_request_ctrl
// Latches hall-up, hall-down and in-cabin floor requests. Each request is
// cleared when the door opens at its floor in a compatible travel direction.
// Also tracks a registered travel direction and drives combinational
// position summaries for the motion and door controllers.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   hall_up/hall_down       hall call buttons (level), one bit per floor
//   car_req                 cabin floor buttons (level)
//   pos                     current car floor
//   open                    door opens at pos this cycle (service event)
//   pend_up/down/car        registered pending requests
//   dir                     registered direction: 00 idle, 01 up, 10 down
//   req_above/below/here    pending work above / below / at pos
//   stop_here               car should stop and open at pos
module elevator_request_ctrl #(
  parameter int unsigned FLOORS = 4,
  parameter int unsigned POS_W  = $clog2(FLOORS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] hall_up,
  input  logic [FLOORS-1:0] hall_down,
  input  logic [FLOORS-1:0] car_req,
  input  logic [POS_W-1:0]  pos,
  input  logic              open,
  output logic [FLOORS-1:0] pend_up,
  output logic [FLOORS-1:0] pend_down,
  output logic [FLOORS-1:0] pend_car,
  output logic [1:0]        dir,
  output logic              req_above,
  output logic              req_below,
  output logic              req_here,
  output logic              stop_here
);

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_e;

  // No up call exists at the top floor and no down call at the bottom floor.
  localparam logic [FLOORS-1:0] UP_MASK   = ~(FLOORS'(1) << (FLOORS - 1));
  localparam logic [FLOORS-1:0] DOWN_MASK = ~FLOORS'(1);

  dir_e              dir_q;
  dir_e              dir_d;
  logic [FLOORS-1:0] any_req;
  logic [FLOORS-1:0] pos_onehot;
  logic              pos_valid;
  logic              below_raw;
  logic              up_clr_ok;
  logic              down_clr_ok;
  logic [FLOORS-1:0] clr_car;
  logic [FLOORS-1:0] clr_up;
  logic [FLOORS-1:0] clr_down;

  // Position summaries; an out-of-range pos yields an all-zero one-hot.
  always_comb begin
    any_req    = pend_up | pend_down | pend_car;
    pos_valid  = (32'(pos) < FLOORS);
    pos_onehot = '0;
    req_above  = 1'b0;
    below_raw  = 1'b0;
    for (int unsigned f = 0; f < FLOORS; f++) begin
      if (32'(pos) == f) pos_onehot[f] = 1'b1;
      if (32'(pos) < f)  req_above = req_above | any_req[f];
      if (32'(pos) > f)  below_raw = below_raw | any_req[f];
    end
    req_below = pos_valid & below_raw;
    req_here  = |(any_req & pos_onehot);
  end

  // A hall call is served only if the car will actually depart in that
  // direction, i.e. it is not still committed to work on the other side.
  always_comb begin
    up_clr_ok   = (dir_q != DIR_DOWN) | ~req_below;
    down_clr_ok = (dir_q != DIR_UP)   | ~req_above;
    stop_here   = |(pos_onehot & (pend_car
                                  | (pend_up   & {FLOORS{up_clr_ok}})
                                  | (pend_down & {FLOORS{down_clr_ok}})));
    clr_car     = pos_onehot & {FLOORS{open}};
    clr_up      = clr_car & {FLOORS{up_clr_ok}};
    clr_down    = clr_car & {FLOORS{down_clr_ok}};
  end

  // Sticky request latches; a clear beats a press in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_up   <= '0;
      pend_down <= '0;
      pend_car  <= '0;
    end else begin
      pend_up   <= (pend_up   | (hall_up & UP_MASK))     & ~clr_up;
      pend_down <= (pend_down | (hall_down & DOWN_MASK)) & ~clr_down;
      pend_car  <= (pend_car  | car_req)                 & ~clr_car;
    end
  end

  // Direction state register.
  always_ff @(posedge clk) begin
    if (reset) dir_q <= DIR_IDLE;
    else       dir_q <= dir_d;
  end

  // Direction next-state: keep going while work remains ahead, else reverse.
  always_comb begin
    dir_d = dir_q;
    unique case (dir_q)
      DIR_IDLE: begin
        if (req_above)      dir_d = DIR_UP;
        else if (req_below) dir_d = DIR_DOWN;
        else                dir_d = DIR_IDLE;
      end
      DIR_UP: begin
        if (req_above)      dir_d = DIR_UP;
        else if (req_below) dir_d = DIR_DOWN;
        else                dir_d = DIR_IDLE;
      end
      DIR_DOWN: begin
        if (req_below)      dir_d = DIR_DOWN;
        else if (req_above) dir_d = DIR_UP;
        else                dir_d = DIR_IDLE;
      end
      default: dir_d = DIR_IDLE;
    endcase
  end

  assign dir = dir_q;

endmodule
